apb_req_arbiter: RTL and testbench

Round-robin arbiter and sequencer sharing the single APB master command port (transfer / READ_WRITE / address / data) between NUM_REQ independent requesters. Accepts one command at a time, holds it stable on the APB command port until the bus signals completion, then returns read data and PSLVERR to the winning requester. Sits directly in front of the APB master in the top-level bus subsystem.

---
 rtl/apb_arb_pkg.sv | 21 ++
 rtl/apb_rr_picker.sv | 32 +++
 rtl/apb_req_arbiter.sv | 131 +++++++++++++
 tb/tb_apb_req_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and defaults for the APB request arbiter.
// Optional timeout support is enabled with APB_ARB_TIMEOUT_EN.
package apb_arb_pkg;

  localparam int unsigned DEF_NUM_REQ        = 4;
  localparam int unsigned DEF_ADDR_WIDTH     = 9;
  localparam int unsigned DEF_DATA_WIDTH     = 8;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // Counter holds 0 .. cycles-1 while waiting in BUSY.
  function automatic int unsigned tmo_cnt_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/apb_rr_picker.sv
// Combinational round-robin selector: first set request at or after ptr wins.
module apb_rr_picker
  import apb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned IDX_W   = (DEF_NUM_REQ > 1) ? $clog2(DEF_NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win_onehot_c,
  output logic [IDX_W-1:0]   win_idx_c
);

  logic        hit;
  int unsigned cand;

  always_comb begin
    win_onehot_c = '0;
    win_idx_c    = '0;
    hit          = 1'b0;
    cand         = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = (32'(ptr) + i) % NUM_REQ;
      if (!hit && req[IDX_W'(cand)]) begin
        hit                          = 1'b1;
        win_idx_c                    = IDX_W'(cand);
        win_onehot_c[IDX_W'(cand)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter/sequencer sharing one APB master command port.
// Define APB_ARB_TIMEOUT_EN to abort transfers that exceed TIMEOUT_CYCLES in BUSY.
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = DEF_NUM_REQ,
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                          PCLK,
  input  logic                          PRESETn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_grant,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          transfer,
  output logic                          READ_WRITE,
  output logic [ADDR_WIDTH-1:0]         apb_write_paddr,
  output logic [DATA_WIDTH-1:0]         apb_write_data,
  output logic [ADDR_WIDTH-1:0]         apb_read_paddr,
  input  logic                          apb_done,
  input  logic [DATA_WIDTH-1:0]         apb_read_data_out,
  input  logic                          PSLVERR
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e           state;
  logic [IDX_W-1:0]     rr_ptr;
  logic [NUM_REQ-1:0]   owner;
  logic [NUM_REQ-1:0]   win_onehot_c;
  logic [IDX_W-1:0]     win_idx_c;
  logic [IDX_W-1:0]     next_ptr_c;
  logic [ADDR_WIDTH-1:0] sel_addr_c;
  logic [DATA_WIDTH-1:0] sel_wdata_c;
  logic                 sel_write_c;

  apb_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req          (req_valid),
    .ptr          (rr_ptr),
    .win_onehot_c (win_onehot_c),
    .win_idx_c    (win_idx_c)
  );

  // Winner's payload, sampled only on the IDLE->BUSY edge.
  assign sel_addr_c  = req_addr[32'(win_idx_c) * ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wdata_c = req_wdata[32'(win_idx_c) * DATA_WIDTH +: DATA_WIDTH];
  assign sel_write_c = req_write[win_idx_c];
  assign next_ptr_c  = (win_idx_c == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx_c + IDX_W'(1);

`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = tmo_cnt_width(TIMEOUT_CYCLES);
  logic [TMO_W-1:0] tmo_cnt;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^32'(TIMEOUT_CYCLES);
`endif

  // Sequencer: one command in flight, command outputs frozen outside IDLE->BUSY.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      owner           <= '0;
      req_grant       <= '0;
      rsp_valid       <= '0;
      rsp_rdata       <= '0;
      rsp_err         <= 1'b0;
      transfer        <= 1'b0;
      READ_WRITE      <= 1'b1;
      apb_write_paddr <= '0;
      apb_read_paddr  <= '0;
      apb_write_data  <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      tmo_cnt         <= '0;
`endif
    end else begin
      req_grant <= '0;
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            req_grant       <= win_onehot_c;
            owner           <= win_onehot_c;
            rr_ptr          <= next_ptr_c;
            transfer        <= 1'b1;
            READ_WRITE      <= !sel_write_c;
            apb_write_paddr <= sel_addr_c;
            apb_read_paddr  <= sel_addr_c;
            if (sel_write_c) apb_write_data <= sel_wdata_c;
`ifdef APB_ARB_TIMEOUT_EN
            tmo_cnt         <= '0;
`endif
            state           <= BUSY;
          end
        end
        BUSY: begin
          if (apb_done) begin
            rsp_valid <= owner;
            rsp_rdata <= READ_WRITE ? apb_read_data_out : '0;
            rsp_err   <= PSLVERR;
            transfer  <= 1'b0;
            state     <= RESP;
          end
`ifdef APB_ARB_TIMEOUT_EN
          else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            rsp_valid <= owner;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            transfer  <= 1'b0;
            state     <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
`endif
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed self-checking bench for apb_req_arbiter (timeout step needs APB_ARB_TIMEOUT_EN).
module tb_apb_req_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 9;
  localparam int unsigned DW = 8;

  logic             PCLK = 1'b0;
  logic             PRESETn;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_write;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]    req_grant;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_err;
  logic             transfer;
  logic             READ_WRITE;
  logic [AW-1:0]    apb_write_paddr;
  logic [DW-1:0]    apb_write_data;
  logic [AW-1:0]    apb_read_paddr;
  logic             apb_done;
  logic [DW-1:0]    apb_read_data_out;
  logic             PSLVERR;

  int total  = 0;
  int passed = 0;

  apb_req_arbiter #(
    .NUM_REQ        (NR),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .PCLK              (PCLK),
    .PRESETn           (PRESETn),
    .req_valid         (req_valid),
    .req_write         (req_write),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .req_grant         (req_grant),
    .rsp_valid         (rsp_valid),
    .rsp_rdata         (rsp_rdata),
    .rsp_err           (rsp_err),
    .transfer          (transfer),
    .READ_WRITE        (READ_WRITE),
    .apb_write_paddr   (apb_write_paddr),
    .apb_write_data    (apb_write_data),
    .apb_read_paddr    (apb_read_paddr),
    .apb_done          (apb_done),
    .apb_read_data_out (apb_read_data_out),
    .PSLVERR           (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_write[i]          = w;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_transfer"}, 32'(transfer), 32'd0);
    check({tag, "_rw"},       32'(READ_WRITE), 32'd1);
    check({tag, "_wpaddr"},   32'(apb_write_paddr), 32'd0);
    check({tag, "_rpaddr"},   32'(apb_read_paddr), 32'd0);
    check({tag, "_wdata"},    32'(apb_write_data), 32'd0);
    check({tag, "_grant"},    32'(req_grant), 32'd0);
    check({tag, "_rspv"},     32'(rsp_valid), 32'd0);
    check({tag, "_rdata"},    32'(rsp_rdata), 32'd0);
    check({tag, "_err"},      32'(rsp_err), 32'd0);
  endtask

  initial begin
    PRESETn = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    apb_done = 1'b0; apb_read_data_out = '0; PSLVERR = 1'b0;
    tick(); tick();
    check_reset_vals("reset");
    PRESETn = 1'b1;
    tick();
    check("idle_no_grant", 32'(req_grant), 32'd0);

    // Fairness: everyone requesting, reads at distinct addresses
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, AW'(9'h040 * i + 3), 8'h00);
    req_valid = 4'hF;
    tick();
    for (int k = 0; k < 5; k++) begin
      check("fair_grant", 32'(req_grant), 32'(1) << (k % 4));
      check("fair_transfer", 32'(transfer), 32'd1);
      check("fair_paddr", 32'(apb_read_paddr), 32'(9'h040 * (k % 4) + 3));
      if (k == 4) req_valid = '0;
      apb_done = 1'b1; apb_read_data_out = 8'(8'h40 + k);
      tick();
      apb_done = 1'b0;
      check("fair_rspv", 32'(rsp_valid), 32'(1) << (k % 4));
      check("fair_rdata", 32'(rsp_rdata), 32'(8'h40 + k));
      check("fair_low1", 32'(transfer), 32'd0);
      tick();
      check("fair_low2", 32'(transfer), 32'd0);
      check("fair_rspv_clr", 32'(rsp_valid), 32'd0);
      tick();
    end
    check("fair_end_nogrant", 32'(req_grant), 32'd0);

    // Single read from requester 1
    set_req(1, 1'b0, 9'h105, 8'h00);
    req_valid = 4'b0010;
    tick();
    check("rd_grant", 32'(req_grant), 32'h2);
    check("rd_transfer", 32'(transfer), 32'd1);
    check("rd_rw", 32'(READ_WRITE), 32'd1);
    check("rd_wpaddr", 32'(apb_write_paddr), 32'h105);
    check("rd_rpaddr", 32'(apb_read_paddr), 32'h105);
    req_valid = '0;
    apb_done = 1'b1; apb_read_data_out = 8'hA5; PSLVERR = 1'b0;
    tick();
    apb_done = 1'b0;
    check("rd_rspv", 32'(rsp_valid), 32'h2);
    check("rd_rdata", 32'(rsp_rdata), 32'hA5);
    check("rd_err", 32'(rsp_err), 32'd0);
    check("rd_grant_clr", 32'(req_grant), 32'd0);
    tick();

    // Write from requester 0 completing with a slave error
    set_req(0, 1'b1, 9'h012, 8'h3C);
    req_valid = 4'b0001;
    tick();
    check("wr_grant", 32'(req_grant), 32'h1);
    check("wr_rw", 32'(READ_WRITE), 32'd0);
    check("wr_wdata", 32'(apb_write_data), 32'h3C);
    check("wr_wpaddr", 32'(apb_write_paddr), 32'h012);
    check("wr_rpaddr", 32'(apb_read_paddr), 32'h012);
    req_valid = '0;
    tick();
    check("wr_hold_transfer", 32'(transfer), 32'd1);
    check("wr_hold_wdata", 32'(apb_write_data), 32'h3C);
    apb_done = 1'b1; PSLVERR = 1'b1; apb_read_data_out = 8'h77;
    tick();
    apb_done = 1'b0; PSLVERR = 1'b0;
    check("wr_rspv", 32'(rsp_valid), 32'h1);
    check("wr_err", 32'(rsp_err), 32'd1);
    check("wr_rdata", 32'(rsp_rdata), 32'd0);
    tick();

    // Stability: payloads churn while the bus stalls
    set_req(2, 1'b0, 9'h1F0, 8'h99);
    req_valid = 4'b0100;
    tick();
    check("stb_grant", 32'(req_grant), 32'h4);
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, AW'(9'h0AA + i), 8'hFF);
    req_valid = 4'hF;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("stb_transfer", 32'(transfer), 32'd1);
      check("stb_rw", 32'(READ_WRITE), 32'd1);
      check("stb_wpaddr", 32'(apb_write_paddr), 32'h1F0);
      check("stb_rpaddr", 32'(apb_read_paddr), 32'h1F0);
      check("stb_wdata", 32'(apb_write_data), 32'h3C);
      check("stb_rspv", 32'(rsp_valid), 32'd0);
    end
    apb_done = 1'b1; apb_read_data_out = 8'h5A;
    tick();
    apb_done = 1'b0;
    check("stb_rspv_done", 32'(rsp_valid), 32'h4);
    check("stb_rdata", 32'(rsp_rdata), 32'h5A);
    tick();
    tick();
    check("rr3_grant", 32'(req_grant), 32'h8);
    check("rr3_rw", 32'(READ_WRITE), 32'd0);
    check("rr3_wpaddr", 32'(apb_write_paddr), 32'h0AD);
    check("rr3_wdata", 32'(apb_write_data), 32'hFF);

    // Reset in the middle of BUSY
    tick();
    #2;
    PRESETn = 1'b0;
    #1;
    check_reset_vals("rst_busy");
    apb_done = 1'b1;
    tick();
    check("rst_no_rsp", 32'(rsp_valid), 32'd0);
    check("rst_no_transfer", 32'(transfer), 32'd0);
    apb_done = 1'b0;
    PRESETn = 1'b1;
    tick();
    check("post_rst_grant", 32'(req_grant), 32'h1);
    req_valid = '0;
    apb_done = 1'b1;
    tick();
    apb_done = 1'b0;
    check("post_rst_rspv", 32'(rsp_valid), 32'h1);
    tick();

`ifdef APB_ARB_TIMEOUT_EN
    // Timeout: bus never completes
    set_req(1, 1'b0, 9'h111, 8'h00);
    req_valid = 4'b0010;
    tick();
    check("tmo_grant", 32'(req_grant), 32'h2);
    req_valid = '0;
    for (int c = 0; c < 15; c++) begin
      tick();
      check("tmo_wait_transfer", 32'(transfer), 32'd1);
      check("tmo_wait_rspv", 32'(rsp_valid), 32'd0);
    end
    tick();
    check("tmo_rspv", 32'(rsp_valid), 32'h2);
    check("tmo_err", 32'(rsp_err), 32'd1);
    check("tmo_rdata", 32'(rsp_rdata), 32'd0);
    check("tmo_transfer", 32'(transfer), 32'd0);
    tick();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
